// File: rtl/i2s_tx.sv
// I2S transmitter: a small sample-pair FIFO feeding a frame sequencer that serialises
// left/right words MSB-first with the one-bit I2S delay. All flops update on falling sclk_i.
`timescale 1ns/1ps

module i2s_tx #(
    parameter int WIDTH = 16,
    parameter int SLOT  = 32,
    parameter int DEPTH = 2
) (
    input  logic             sclk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] left_i,
    input  logic [WIDTH-1:0] right_i,
    output logic             ws_o,
    output logic             sdata_o,
    output logic             frame_start_o,
    output logic             underflow_o,
    output logic [0:0]       dbg_state_o
);

    localparam int FRAME = 2 * SLOT;
    localparam int KW    = $clog2(FRAME);
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    localparam logic [KW-1:0] K_LAST  = KW'(FRAME - 1);
    localparam logic [KW-1:0] K_SLOT  = KW'(SLOT);
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [KW-1:0]    r_k;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_right_hold;
    logic             r_ws;
    logic             r_sdata;
    logic             r_frame_start;
    logic             r_underflow;

    logic [WIDTH-1:0] r_fifo_l [DEPTH];
    logic [WIDTH-1:0] r_fifo_r [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_last;
    logic             w_frame_edge;
    logic [KW-1:0]    w_k_inc;

    // Handshake: a pair transfers on a falling edge where in_valid_i and in_ready_o are
    // both high; in_ready_o depends only on the FIFO count, never on in_valid_i.
    always_comb begin
        w_empty      = (r_count == '0);
        in_ready_o   = (r_count < C_DEPTH);
        w_push       = in_valid_i & in_ready_o;
        w_last       = (r_k == K_LAST);
        w_frame_edge = en_i & ((r_state == S_IDLE) | w_last);
        w_pop        = w_frame_edge & ~w_empty;
        w_k_inc      = r_k + KW'(1);
    end

    always_ff @(negedge sclk_i) begin
        if (w_push) begin
            r_fifo_l[r_wr_ptr] <= left_i;
            r_fifo_r[r_wr_ptr] <= right_i;
        end
    end

    always_ff @(negedge sclk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Left word goes straight into the shifter at frame start; right word waits in a hold
    // register until the slot boundary so the FIFO entry is released immediately.
    always_ff @(negedge sclk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state       <= S_IDLE;
            r_k           <= '0;
            r_shift       <= '0;
            r_right_hold  <= '0;
            r_ws          <= 1'b0;
            r_sdata       <= 1'b0;
            r_frame_start <= 1'b0;
            r_underflow   <= 1'b0;
        end else if (w_frame_edge) begin
            r_state       <= S_RUN;
            r_k           <= '0;
            r_shift       <= w_empty ? '0 : r_fifo_l[r_rd_ptr];
            r_right_hold  <= w_empty ? '0 : r_fifo_r[r_rd_ptr];
            r_ws          <= 1'b0;
            r_sdata       <= 1'b0;
            r_frame_start <= 1'b1;
            r_underflow   <= w_empty;
        end else if ((r_state == S_RUN) && !w_last) begin
            r_k           <= w_k_inc;
            r_ws          <= (w_k_inc >= K_SLOT);
            r_frame_start <= 1'b0;
            r_underflow   <= 1'b0;
            if (w_k_inc == K_SLOT) begin
                r_shift <= r_right_hold;
                r_sdata <= 1'b0;
            end else begin
                // Zeros shift in behind the word, so periods past WIDTH emit 0.
                r_sdata <= r_shift[WIDTH-1];
                r_shift <= {r_shift[WIDTH-2:0], 1'b0};
            end
        end else begin
            r_state       <= S_IDLE;
            r_k           <= '0;
            r_ws          <= 1'b0;
            r_sdata       <= 1'b0;
            r_frame_start <= 1'b0;
            r_underflow   <= 1'b0;
        end
    end

    assign ws_o          = r_ws;
    assign sdata_o       = r_sdata;
    assign frame_start_o = r_frame_start;
    assign underflow_o   = r_underflow;
    assign dbg_state_o   = r_state;

endmodule
